// File: rtl/doom_pkg.sv
// Types and map-size defaults shared by the player controller and map/renderer logic.
package doom_pkg;

   localparam int MAP_W_DEF = 16;
   localparam int MAP_H_DEF = 16;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_QUERY,
      ST_WAIT_RELEASE
   } pstate_t;

endpackage

// File: rtl/release_debouncer.sv
// Asserts released_o once pressed_i has been low for CYCLES consecutive cycles,
// counting the current cycle. Any pressed_i=1 restarts the count.
module release_debouncer #(
   parameter int CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic pressed_i,
   output logic released_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pressed_i)
         cnt_d = '0;
      else if (cnt_q != CW'(CYCLES))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign released_o = !pressed_i && (cnt_q >= CW'(CYCLES - 1));

endmodule

// File: rtl/player_controller.sv
// Turns synchronized button presses into one player action each (turn or wall-checked step).
// Optional release debounce: define PLAYER_CTRL_DEBOUNCE_EN.
module player_controller
   import doom_pkg::*;
#(
   parameter int MAP_W           = MAP_W_DEF,
   parameter int MAP_H           = MAP_H_DEF,
   parameter int X_W             = 4,
   parameter int Y_W             = 4,
   parameter int START_X         = 1,
   parameter int START_Y         = 1,
   parameter int START_DIR       = 0,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rotateN90_press,
   input  logic           forward_press,
   input  logic           rotate90_press,
   input  logic           pressed,
   output logic           wall_req,
   output logic [X_W-1:0] wall_x,
   output logic [Y_W-1:0] wall_y,
   input  logic           wall_ack,
   input  logic           wall_hit,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic [1:0]     dir,
   output logic           moved,
   output logic           blocked,
   output logic           busy
);

   // bit 3 = pressed, 2 = rotate90, 1 = forward, 0 = rotateN90
   logic [3:0] sync1_q, sync2_q;
   logic       s_rn90, s_fwd, s_r90, s_any;
   logic       release_ok;

   pstate_t        state_q, state_d;
   dir_t           dir_q, dir_d;
   logic [X_W-1:0] pos_x_q, pos_x_d, wall_x_q, wall_x_d, tgt_x;
   logic [Y_W-1:0] pos_y_q, pos_y_d, wall_y_q, wall_y_d, tgt_y;
   logic           moved_q, moved_d, blocked_q, blocked_d;
   logic           oob;

   // The pressed bit resets high so a button held through reset reads as
   // still down until real samples arrive, keeping WAIT_RELEASE closed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 4'b1000;
         sync2_q <= 4'b1000;
      end else begin
         sync1_q <= {pressed, rotate90_press, forward_press, rotateN90_press};
         sync2_q <= sync1_q;
      end
   end

   assign {s_any, s_r90, s_fwd, s_rn90} = sync2_q;

`ifdef PLAYER_CTRL_DEBOUNCE_EN
   release_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_release_debouncer (
      .clk       (clk),
      .rst       (rst),
      .pressed_i (s_any),
      .released_o(release_ok)
   );
`else
   logic unused_debounce;
   assign unused_debounce = (DEBOUNCE_CYCLES == 0);
   assign release_ok      = !s_any;
`endif

   always_comb begin
      tgt_x = pos_x_q;
      tgt_y = pos_y_q;
      oob   = 1'b0;
      case (dir_q)
         DIR_N: begin oob = (pos_y_q == '0);             tgt_y = pos_y_q - Y_W'(1); end
         DIR_E: begin oob = (pos_x_q == X_W'(MAP_W - 1)); tgt_x = pos_x_q + X_W'(1); end
         DIR_S: begin oob = (pos_y_q == Y_W'(MAP_H - 1)); tgt_y = pos_y_q + Y_W'(1); end
         default: begin oob = (pos_x_q == '0);           tgt_x = pos_x_q - X_W'(1); end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      wall_x_d  = wall_x_q;
      wall_y_d  = wall_y_q;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_r90) begin
               dir_d   = dir_t'(dir_q + 2'd1);
               state_d = ST_WAIT_RELEASE;
            end else if (s_rn90) begin
               dir_d   = dir_t'(dir_q - 2'd1);
               state_d = ST_WAIT_RELEASE;
            end else if (s_fwd) begin
               if (oob) begin
                  blocked_d = 1'b1;
                  state_d   = ST_WAIT_RELEASE;
               end else begin
                  wall_x_d = tgt_x;
                  wall_y_d = tgt_y;
                  state_d  = ST_QUERY;
               end
            end else if (s_any) begin
               state_d = ST_WAIT_RELEASE;
            end
         end
         ST_QUERY: begin
            if (wall_ack) begin
               if (wall_hit) begin
                  blocked_d = 1'b1;
               end else begin
                  pos_x_d = wall_x_q;
                  pos_y_d = wall_y_q;
                  moved_d = 1'b1;
               end
               state_d = ST_WAIT_RELEASE;
            end
         end
         default: begin
            if (release_ok) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_WAIT_RELEASE;
         dir_q     <= dir_t'(2'(START_DIR));
         pos_x_q   <= X_W'(START_X);
         pos_y_q   <= Y_W'(START_Y);
         wall_x_q  <= '0;
         wall_y_q  <= '0;
         moved_q   <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         wall_x_q  <= wall_x_d;
         wall_y_q  <= wall_y_d;
         moved_q   <= moved_d;
         blocked_q <= blocked_d;
      end
   end

   assign wall_req = (state_q == ST_QUERY);
   assign busy     = (state_q != ST_IDLE);
   assign wall_x   = wall_x_q;
   assign wall_y   = wall_y_q;
   assign pos_x    = pos_x_q;
   assign pos_y    = pos_y_q;
   assign dir      = dir_q;
   assign moved    = moved_q;
   assign blocked  = blocked_q;

endmodule

// File: doc/player_controller.md
# player_controller

Sequential consumer of the one-hot button press signals from the button decoder (rotate-left, forward, rotate-right, any-pressed). Converts each distinct press into exactly one player action on the grid map: a ±90° heading change, or a one-cell forward step gated by a wall lookup handshake with the map store. The block sits between the button decoder and the renderer/map logic, and owns the player's position and heading registers.

## Interface
Parameters:
- MAP_W, 16, map width in cells
- MAP_H, 16, map height in cells
- X_W, 4, width of x coordinate (≥ clog2(MAP_W))
- Y_W, 4, width of y coordinate (≥ clog2(MAP_H))
- START_X, 1, x position at reset
- START_Y, 1, y position at reset
- START_DIR, 0, heading at reset (0=N, 1=E, 2=S, 3=W)
- DEBOUNCE_CYCLES, 1000000, stable-release cycles (used only with debounce compiled in)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rotateN90_press  in  1  rotate-left request (one-hot with the others)
- forward_press  in  1  step-forward request
- rotate90_press  in  1  rotate-right request
- pressed  in  1  any button down, including illegal multi-press
- wall_req  out  1  wall lookup request, held until ack
- wall_x  out  X_W  lookup x, stable while wall_req=1
- wall_y  out  Y_W  lookup y, stable while wall_req=1
- wall_ack  in  1  lookup response valid
- wall_hit  in  1  target cell is solid; sampled with wall_ack
- pos_x  out  X_W  player x
- pos_y  out  Y_W  player y
- dir  out  2  player heading
- moved  out  1  one-cycle pulse on a completed step
- blocked  out  1  one-cycle pulse on a refused step
- busy  out  1  high whenever state ≠ IDLE

## Operation
- All four press inputs pass through a 2-flop synchronizer; the FSM sees only the synchronized values.
- States: IDLE, QUERY, WAIT_RELEASE. Reset state is WAIT_RELEASE, so a button held through reset never triggers an action.
- IDLE: rotate90 → dir ← dir+1 mod 4, go to WAIT_RELEASE. rotateN90 → dir ← dir−1 mod 4, go to WAIT_RELEASE. forward → compute target cell (N: y−1, E: x+1, S: y+1, W: x−1). pressed with no one-hot bit (multi-press) → no action, go to WAIT_RELEASE.
- Forward target out of bounds (x=0 going W, x=MAP_W−1 going E, y=0 going N, y=MAP_H−1 going S) → no lookup, pulse blocked, go to WAIT_RELEASE. Otherwise latch wall_x/wall_y and go to QUERY.
- QUERY: wall_req=1. On a cycle with wall_ack=1: if wall_hit=0, pos ← target and pulse moved; if wall_hit=1, pulse blocked. Either way go to WAIT_RELEASE. wall_ack outside QUERY is ignored.
- WAIT_RELEASE: return to IDLE once the release condition (see Configuration) is met. Presses in this state are ignored.
- Coordinates never wrap; all arithmetic stays within MAP bounds.

## Timing
- Reset values: pos_x=START_X, pos_y=START_Y, dir=START_DIR, wall_req=0, wall_x=0, wall_y=0, moved=0, blocked=0, busy=1.
- Rotation: dir updates on the 3rd rising edge after the raw press rises (2 sync + 1).
- Forward: wall_req rises on the 3rd edge. A combinational responder (ack in the first QUERY cycle) lets pos update on the 4th edge. moved/blocked are high for exactly one cycle, coincident with the first cycle of the new pos.
- Asserting rst mid-QUERY drops wall_req immediately (asynchronously) and restores the start pose.
- Unlimited ack latency; no timeout.

## Configuration
- PLAYER_CTRL_DEBOUNCE_EN defined: WAIT_RELEASE → IDLE only after synchronized pressed=0 for DEBOUNCE_CYCLES consecutive cycles. Any pressed=1 during the count restarts it.
- Undefined: a single cycle of synchronized pressed=0 returns the FSM to IDLE. DEBOUNCE_CYCLES is unused.

## Structure
- Shared package doom_pkg: dir_t enum (DIR_N, DIR_E, DIR_S, DIR_W) and the player FSM state enum. The map-size defaults live here too.
- One sub-module, release_debouncer: counter plus stable-low detect, instantiated only under PLAYER_CTRL_DEBOUNCE_EN.

## Test plan
- Reset with forward held, release, press rotate90 once → no step during hold; dir goes 0→1 once; pos stays (1,1).
- Hold rotateN90 for 50 cycles from dir=0 → dir=3 exactly once; no second change until release.
- At (1,1) facing E, forward, ack after 5 cycles with hit=0 → wall_x=2, wall_y=1 stable while wall_req=1; pos=(2,1); moved pulses one cycle.
- Same scenario with hit=1 → pos stays (1,1); blocked pulses; moved stays 0.
- At (0,1) facing W, forward → wall_req never asserts; blocked pulses.
- Multi-press (pressed=1, no one-hot bit) → no pose change; busy high until release. Reset mid-QUERY → wall_req=0 immediately and start pose restored.
